// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix-multiply result path.
package mm_pkg;
  localparam int D_W_ACC_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } res_state_t;
endpackage

// File: rtl/mm_res_bram.sv
// Simple dual-port result RAM: one write port, one registered read port (read-first, 1-cycle latency).
// Read data register clears on rst and otherwise holds when no read is issued.
module mm_res_bram
  import mm_pkg::*;
#(
  parameter int DATA_W = D_W_ACC_DEF,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Non-blocking read of the array gives old data on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mm_res_s2mm.sv
// Result stream sink: captures LEN AXI-stream words into the result RAM and flags framing errors.
// tready is high only while receiving; define MM_RES_CHECKSUM_EN to add a wrapping checksum output.
module mm_res_s2mm
  import mm_pkg::*;
#(
  parameter int D_W_ACC      = D_W_ACC_DEF,
  parameter int MATRIXSIZE_W = 24,
  parameter int MEM_DEPTH_R  = 4096,
  parameter int ADDR_W_R     = $clog2(MEM_DEPTH_R)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] LEN,
  input  logic [D_W_ACC-1:0]      s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    rd_en,
  input  logic [ADDR_W_R-1:0]     rd_addr,
  output logic [D_W_ACC-1:0]      rd_data,
  output logic [MATRIXSIZE_W-1:0] word_cnt,
  output logic                    done,
  output logic                    err_early,
  output logic                    err_missing,
`ifdef MM_RES_CHECKSUM_EN
  output logic [D_W_ACC-1:0]      checksum,
`endif
  output logic                    err_len
);
  localparam logic [MATRIXSIZE_W-1:0] DEPTH_L = MATRIXSIZE_W'(MEM_DEPTH_R);

  res_state_t              state_q, state_d;
  logic [MATRIXSIZE_W-1:0] len_q, len_d;
  logic [MATRIXSIZE_W-1:0] cnt_q, cnt_d;
  logic                    early_q, early_d;
  logic                    miss_q, miss_d;
  logic                    elen_q, elen_d;
  logic                    beat;
  logic                    last_idx;
  logic                    start_acc;

  assign s_axis_tready = (state_q == RECV);
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign last_idx      = (cnt_q == len_q - 1'b1);
  assign start_acc     = start & (state_q != RECV);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    early_d = early_q;
    miss_d  = miss_q;
    elen_d  = elen_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d   = LEN;
          cnt_d   = '0;
          early_d = 1'b0;
          miss_d  = 1'b0;
          elen_d  = (LEN > DEPTH_L);
          state_d = ((LEN == '0) || (LEN > DEPTH_L)) ? DONE : RECV;
        end
      end
      RECV: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (last_idx) begin
            miss_d  = ~s_axis_tlast;
            state_d = DONE;
          end else if (s_axis_tlast) begin
            early_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      early_q <= 1'b0;
      miss_q  <= 1'b0;
      elen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      early_q <= early_d;
      miss_q  <= miss_d;
      elen_q  <= elen_d;
    end
  end

`ifdef MM_RES_CHECKSUM_EN
  logic [D_W_ACC-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_acc) sum_d = '0;
    else if (beat) sum_d = sum_q + s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

  assign word_cnt    = cnt_q;
  assign done        = (state_q == DONE);
  assign err_early   = early_q;
  assign err_missing = miss_q;
  assign err_len     = elen_q;

  // Writes are blocked during reset so an in-flight beat cannot land after the abort.
  mm_res_bram #(
    .DATA_W (D_W_ACC),
    .DEPTH  (MEM_DEPTH_R),
    .ADDR_W (ADDR_W_R)
  ) u_bram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (beat & ~rst),
    .waddr_i (cnt_q[ADDR_W_R-1:0]),
    .wdata_i (s_axis_tdata),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );
endmodule
